// File: rtl/usb_stat_matcher_pkg.sv
// Shared constants for the multi-channel USB STAT matcher.
// Holds the capture-mode encodings and the channel state type.
package usb_stat_matcher_pkg;

    localparam logic [1:0] MATCH_MODE_FIRST = 2'd0;
    localparam logic [1:0] MATCH_MODE_COUNT = 2'd1;
    localparam logic [1:0] MATCH_MODE_LAST  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } chan_state_e;

    // Mode 3 is reserved and behaves like FIRST.
    function automatic logic is_single_shot(input logic [1:0] mode);
        return !(mode == MATCH_MODE_COUNT || mode == MATCH_MODE_LAST);
    endfunction

endpackage

// File: rtl/usb_stat_match_chan.sv
// One match channel: run counter, state machine and result registers.
// In: control strobes, s1 status, latched config, timestamp. Out: results, pulse.
module usb_stat_match_chan
    import usb_stat_matcher_pkg::*;
#(
    parameter int pSTAT_WIDTH  = 5,
    parameter int pDUR_WIDTH   = 8,
    parameter int pCOUNT_WIDTH = 16,
    parameter int pTS_WIDTH    = 24
) (
    input  logic                    fe_clk,
    input  logic                    reset_n,
    input  logic                    armed,
    input  logic                    restart,
    input  logic                    zero,
    input  logic                    chain,
    input  logic                    prev_first,
    input  logic [pSTAT_WIDTH-1:0]  stat,
    input  logic [pSTAT_WIDTH-1:0]  pattern,
    input  logic [pSTAT_WIDTH-1:0]  mask,
    input  logic [pDUR_WIDTH-1:0]   min_dur,
    input  logic [1:0]              mode,
    input  logic [pTS_WIDTH-1:0]    ts,
    output logic                    first_event,
    output logic                    captured,
    output logic                    match_pulse,
    output logic [pSTAT_WIDTH-1:0]  cap_stat,
    output logic [pCOUNT_WIDTH-1:0] count,
    output logic [pTS_WIDTH-1:0]    cap_ts
);

    chan_state_e             state, state_nxt;
    logic [pDUR_WIDTH-1:0]   run, run_nxt;
    logic                    fired, fired_nxt;
    logic                    hit, event_now;

    always_comb begin
        hit         = ((stat ^ pattern) & mask) == '0;
        // fired blocks a second event in the same unbroken run,
        // even when the run counter sits saturated at min_dur
        event_now   = armed && !zero && (state == ST_ACTIVE) &&
                      hit && !fired && (run == min_dur);
        first_event = event_now && !captured;

        state_nxt = state;
        if (restart) begin
            state_nxt = chain ? ST_WAIT : ST_ACTIVE;
        end else if (!armed) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_WAIT:   if (prev_first) state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (event_now && is_single_shot(mode))
                               state_nxt = ST_DONE;
                ST_IDLE:   state_nxt = state;
                ST_DONE:   state_nxt = state;
            endcase
        end

        run_nxt   = '0;
        fired_nxt = 1'b0;
        if (!zero && state == ST_ACTIVE && hit) begin
            run_nxt   = (run == '1) ? run : run + 1'b1;
            fired_nxt = fired | event_now;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            run   <= '0;
            fired <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            fired <= fired_nxt;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            captured    <= 1'b0;
            match_pulse <= 1'b0;
            cap_stat    <= '0;
            count       <= '0;
            cap_ts      <= '0;
        end else if (zero) begin
            captured    <= 1'b0;
            match_pulse <= 1'b0;
            cap_stat    <= '0;
            count       <= '0;
            cap_ts      <= '0;
        end else begin
            match_pulse <= event_now;
            if (event_now) begin
                captured <= 1'b1;
                if (count != '1) count <= count + 1'b1;
                if (!captured || mode == MATCH_MODE_LAST) begin
                    cap_stat <= stat;
                    cap_ts   <= ts;
                end
            end
        end
    end

endmodule

// File: rtl/usb_stat_matcher.sv
// Multi-channel USB STAT matcher: input register, arm/clear control, config latch,
// timestamp, chain wiring and trigger OR around pCHANNELS match channels.
module usb_stat_matcher
    import usb_stat_matcher_pkg::*;
#(
    parameter int pCHANNELS    = 4,
    parameter int pSTAT_WIDTH  = 5,
    parameter int pDUR_WIDTH   = 8,
    parameter int pCOUNT_WIDTH = 16,
    parameter int pTS_WIDTH    = 24
) (
    input  logic                              fe_clk,
    input  logic                              reset_n,
    input  logic                              I_arm,
    input  logic                              I_clear,
    input  logic [pSTAT_WIDTH-1:0]            I_fe_capture_stat,
    input  logic [pCHANNELS*pSTAT_WIDTH-1:0]  I_pattern,
    input  logic [pCHANNELS*pSTAT_WIDTH-1:0]  I_mask,
    input  logic [pCHANNELS*pDUR_WIDTH-1:0]   I_min_dur,
    input  logic [pCHANNELS*2-1:0]            I_mode,
    input  logic [pCHANNELS-1:0]              I_chain,
    output logic [pCHANNELS-1:0]              O_captured,
    output logic [pCHANNELS*pSTAT_WIDTH-1:0]  O_stat,
    output logic [pCHANNELS*pCOUNT_WIDTH-1:0] O_count,
    output logic [pCHANNELS*pTS_WIDTH-1:0]    O_timestamp,
    output logic [pCHANNELS-1:0]              O_match_pulse,
    output logic                              O_trigger
);

    localparam logic [pCHANNELS-1:0] CHAIN_HEAD = pCHANNELS'(1);

    logic [pSTAT_WIDTH-1:0]           s1;
    logic                             arm_q;
    logic [pCHANNELS*pSTAT_WIDTH-1:0] cfg_pattern, cfg_mask;
    logic [pCHANNELS*pDUR_WIDTH-1:0]  cfg_dur;
    logic [pCHANNELS*2-1:0]           cfg_mode;
    logic [pCHANNELS-1:0]             cfg_chain;
    logic [pTS_WIDTH-1:0]             ts;
    logic [pCHANNELS-1:0]             chain_sel, first_event, link;
    logic                             arm_edge, restart, zero;

    assign arm_edge = I_arm && !arm_q;
    // clear while armed restarts the run on the already latched config
    assign restart  = arm_edge || (I_clear && I_arm);
    assign zero     = arm_edge || I_clear;
    // on the arm edge the config is not latched yet, so use the live chain bits
    assign chain_sel = (arm_edge ? I_chain : cfg_chain) & ~CHAIN_HEAD;
    assign link      = first_event << 1;
    assign O_trigger = |O_match_pulse;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= '0;
            arm_q <= 1'b0;
        end else begin
            s1    <= I_fe_capture_stat;
            arm_q <= I_arm;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_pattern <= '0;
            cfg_mask    <= '0;
            cfg_dur     <= '0;
            cfg_mode    <= '0;
            cfg_chain   <= '0;
        end else if (arm_edge) begin
            cfg_pattern <= I_pattern;
            cfg_mask    <= I_mask;
            cfg_dur     <= I_min_dur;
            cfg_mode    <= I_mode;
            cfg_chain   <= I_chain;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
        end else if (restart) begin
            ts <= '0;
        end else if (I_arm && ts != '1) begin
            ts <= ts + 1'b1;
        end
    end

    for (genvar k = 0; k < pCHANNELS; k++) begin : g_chan
        usb_stat_match_chan #(
            .pSTAT_WIDTH  (pSTAT_WIDTH),
            .pDUR_WIDTH   (pDUR_WIDTH),
            .pCOUNT_WIDTH (pCOUNT_WIDTH),
            .pTS_WIDTH    (pTS_WIDTH)
        ) u_chan (
            .fe_clk      (fe_clk),
            .reset_n     (reset_n),
            .armed       (I_arm),
            .restart     (restart),
            .zero        (zero),
            .chain       (chain_sel[k]),
            .prev_first  (link[k]),
            .stat        (s1),
            .pattern     (cfg_pattern[k*pSTAT_WIDTH +: pSTAT_WIDTH]),
            .mask        (cfg_mask[k*pSTAT_WIDTH +: pSTAT_WIDTH]),
            .min_dur     (cfg_dur[k*pDUR_WIDTH +: pDUR_WIDTH]),
            .mode        (cfg_mode[k*2 +: 2]),
            .ts          (ts),
            .first_event (first_event[k]),
            .captured    (O_captured[k]),
            .match_pulse (O_match_pulse[k]),
            .cap_stat    (O_stat[k*pSTAT_WIDTH +: pSTAT_WIDTH]),
            .count       (O_count[k*pCOUNT_WIDTH +: pCOUNT_WIDTH]),
            .cap_ts      (O_timestamp[k*pTS_WIDTH +: pTS_WIDTH])
        );
    end

endmodule

// File: doc/usb_stat_matcher.md
Name: usb_stat_matcher

Overview:
- Multi-channel successor to the single USB STAT match monitor in the PW-USB front end; lives entirely in the fe_clk domain.
- Each of pCHANNELS channels compares the UTMI capture status against its own masked pattern.
- Adds three things the single monitor lacks: a minimum-duration qualifier, first/count/last capture modes, and channel chaining for sequence detection.
- Results (flag, stat, count, timestamp) go to the register block through its existing CDC; per-channel match pulses feed the trigger generator.

Parameters:
- pCHANNELS, 4: number of match channels (1..8).
- pSTAT_WIDTH, 5: width of I_fe_capture_stat.
- pDUR_WIDTH, 8: width of the per-channel minimum-duration setting.
- pCOUNT_WIDTH, 16: event counter width; counter saturates.
- pTS_WIDTH, 24: timestamp counter width; counter saturates.

Ports:
- fe_clk  in  1  front-end clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm  in  1  arm level, already synchronised to fe_clk. Its rising edge starts a run.
- I_clear  in  1  single-cycle pulse that clears results.
- I_fe_capture_stat  in  pSTAT_WIDTH  live USB status.
- I_pattern  in  pCHANNELS*pSTAT_WIDTH  per-channel pattern.
- I_mask  in  pCHANNELS*pSTAT_WIDTH  per-channel mask; 1 = compare this bit.
- I_min_dur  in  pCHANNELS*pDUR_WIDTH  consecutive matching cycles required, minus 1.
- I_mode  in  pCHANNELS*2  capture mode.
- I_chain  in  pCHANNELS  bit k=1: channel k waits for channel k-1. Bit 0 is ignored.
- O_captured  out  pCHANNELS  channel has seen at least one event.
- O_stat  out  pCHANNELS*pSTAT_WIDTH  captured status value.
- O_count  out  pCHANNELS*pCOUNT_WIDTH  event count.
- O_timestamp  out  pCHANNELS*pTS_WIDTH  timestamp counter value at the captured event.
- O_match_pulse  out  pCHANNELS  one-cycle pulse per event.
- O_trigger  out  1  OR of O_match_pulse.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; all channels IDLE; timestamp counter 0.
- Pipeline:
  - I_fe_capture_stat is registered once (s1); matching is evaluated on s1.
  - Outputs are registered, so O_match_pulse is high 2 cycles after the input cycle that completes qualification.
  - O_captured/O_stat/O_count/O_timestamp update in the same cycle as the pulse.
- Arm (rising edge of I_arm, seen as I_arm high and the previous-cycle sample low):
  - I_pattern, I_mask, I_min_dur, I_mode and I_chain are latched. Config changes while armed are ignored.
  - All results are cleared; the timestamp counter is set to 0 and run counters are reset.
  - Channels with chain=0 (and always channel 0) enter ACTIVE; the rest enter WAIT.
- Timestamp counter: +1 every cycle while I_arm is high; saturates at all-ones.
- Run counter (per channel, ACTIVE only):
  - raw match = (s1 & mask) == (pattern & mask).
  - Increments on every raw-match cycle and saturates; resets to 0 on any mismatch.
  - Event = the cycle the run counter equals min_dur. min_dur=0 gives an event on the first matching cycle.
  - At most one event per unbroken match run.
- Channel state machine:
  - IDLE -> ACTIVE or WAIT on arm.
  - WAIT -> ACTIVE on the cycle after channel k-1's first event. The run counter starts from 0 on entry, so channels k-1 and k can never fire in the same cycle.
  - ACTIVE -> DONE after the first event in FIRST mode only.
  - Any state -> IDLE when I_arm goes low. Results are held in IDLE.
- Modes:
  - 0 FIRST: on the event, capture stat and timestamp, count=1, go to DONE.
  - 1 COUNT: count increments on every event; stat and timestamp are those of the first event.
  - 2 LAST: count increments; stat and timestamp are overwritten on every event.
  - 3: reserved, behaves as FIRST.
- I_clear:
  - Zeroes results and run counters.
  - If armed, it acts as a re-arm using the configuration already latched (it does not re-latch). The timestamp counter is also reset to 0.
  - I_clear and the arm edge in the same cycle: the arm edge wins and the new config is latched.
- Saturation: count and timestamp hold at all-ones and never wrap.
- Reset mid-run: everything returns to reset values immediately; there is no pending pulse.

Decomposition:
- Shared package/defines file (defines_usb.v), added constants:
  - MATCH_MODE_FIRST=2'd0, MATCH_MODE_COUNT=2'd1, MATCH_MODE_LAST=2'd2.
  - Channel state encodings IDLE/WAIT/ACTIVE/DONE.
- One sub-module, usb_stat_match_chan: a single channel (run counter, state machine, result registers), instantiated pCHANNELS times with generate.
- The top level holds the input register, arm-edge detect, config latch, timestamp counter, chain wiring and the trigger OR.

Test Plan:
- Basic capture: ch0 FIRST, pattern 5'h03, mask 5'h1F, min_dur 0. Arm, then drive stat=03 at cycle 10 -> O_match_pulse[0] at cycle 12, O_stat[0]=03, O_timestamp[0]=10, O_count[0]=1, no further pulses.
- Duration filter: min_dur=3. Stat=03 for 3 cycles, then 02, then 03 for 4 cycles -> exactly one pulse, 2 cycles after the 4th consecutive match.
- COUNT and LAST: ch1 COUNT, ch2 LAST, both mask 5'h01 pattern 1. Toggle bit0 five times -> both counts=5. ch1 keeps the first timestamp; ch2 holds the fifth timestamp.
- Chaining: ch1 chain=1, ch1 pattern equal to ch0 pattern, stat held matching -> ch0 fires first; ch1 fires a later cycle (never the same cycle).
- Saturation: pCOUNT_WIDTH=4, 20 events -> O_count=4'hF.
- Control corners:
  - I_clear mid-run: results go to 0 and counting restarts.
  - Arm and clear in the same cycle: the new config is used.
  - reset_n low mid-run: all outputs 0 asynchronously.
